// File: rtl/div_sequencer_if.sv
// div_sequencer_if: EX-stage request/response bundle for the multi-cycle divider.
// The master side is the pipeline; the slave side is the divider.
interface div_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stall_req;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, signed_op, dividend, divisor, annul,
        input  stall_req, busy, result_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, signed_op, dividend, divisor, annul,
        output stall_req, busy, result_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring DIV/DIVU sequencer feeding HI (remainder) / LO (quotient).
// Define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rstn,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dq_q, dq_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic             sgn_op_q, sgn_op_d, sa_q, sa_d, sb_q, sb_d;
    logic             valid_q, valid_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] mag_a, mag_b, rem_sh;
    logic [WIDTH:0]   trial;
    logic             take, early;
    assign mag_a  = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign mag_b  = (bus.signed_op && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
    // Shifted-in partial remainder is WIDTH+1 bits, so the borrow bit decides the quotient bit
    assign trial  = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
    assign take   = ~trial[WIDTH];
    assign rem_sh = take ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
`ifdef DIV_EARLY_OUT_EN
    assign early = mag_a < mag_b;
`else
    assign early = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
        sgn_op_d = sgn_op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        valid_d  = 1'b0;
        dbz_d    = 1'b0;
        if (bus.annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    sgn_op_d = bus.signed_op;
                    sa_d     = bus.dividend[WIDTH-1];
                    sb_d     = bus.divisor[WIDTH-1];
                    rem_d    = '0;
                    cnt_d    = '0;
                    dvs_d    = mag_b;
                    // ZERO reports the raw dividend, so keep it unmodified in that case
                    dq_d     = (bus.divisor == '0) ? bus.dividend : mag_a;
                    if (bus.divisor == '0) begin
                        state_d = ZERO;
                    end else if (early) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        quo_d   = '0;
                        rmd_d   = bus.dividend;
                    end else begin
                        state_d = BUSY;
                    end
                end
                ZERO: begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dbz_d   = 1'b1;
                    quo_d   = '1;
                    rmd_d   = dq_q;
                end
                BUSY: begin
                    rem_d = rem_sh;
                    dq_d  = {dq_q[WIDTH-2:0], take};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        quo_d   = (sgn_op_q && (sa_q ^ sb_q)) ? -dq_d : dq_d;
                        rmd_d   = (sgn_op_q && sa_q) ? -rem_sh : rem_sh;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rmd_q    <= '0;
            sgn_op_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            valid_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            sgn_op_q <= sgn_op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            valid_q  <= valid_d;
            dbz_q    <= dbz_d;
        end
    end
    assign bus.stall_req    = (state_q == IDLE && bus.start && !bus.annul) || state_q == BUSY || state_q == ZERO;
    assign bus.busy         = state_q != IDLE;
    assign bus.result_valid = valid_q;
    assign bus.quotient     = quo_q;
    assign bus.remainder    = rmd_q;
    assign bus.div_by_zero  = dbz_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed divides with a scoreboard queue checked by a result monitor.
// Define DIV_EARLY_OUT_EN to expect the short latency on the 3/10 case.
module tb_div_sequencer;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          issue;
        int          lat;
    } exp_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    div_sequencer_if #(.WIDTH(32)) dif ();
    div_sequencer #(.WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(dif));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask
    // Monitor: every result pulse must match the oldest outstanding expectation
    initial forever begin
        @(negedge clk);
        if (rstn && dif.result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", dif.quotient, e.q);
                chk("remainder", dif.remainder, e.r);
                chk("div_by_zero", {31'd0, dif.div_by_zero}, {31'd0, e.z});
                chk("latency", cyc - e.issue, e.lat);
                chk("stall_in_done", {31'd0, dif.stall_req}, 32'd0);
            end
        end
    end
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.signed_op = sgn;
        dif.dividend  = a;
        dif.divisor   = b;
    endtask
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez, input int lat);
        int  n = 0;
        bit  done = 0;
        issue(sgn, a, b);
        sb.push_back('{q: eq, r: er, z: ez, issue: cyc, lat: lat});
        #1 if (dif.stall_req) n++;
        @(posedge clk);
        #1 dif.start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (dif.result_valid) done = 1;
            else if (dif.stall_req) n++;
        end
        if (!done) chk("result_timeout", 32'd0, 32'd1);
        chk("stall_cycles", n, lat);
        @(negedge clk);
    endtask
    task automatic check_idle_outputs(input string nm, input logic [31:0] q);
        chk({nm, "_busy"}, {31'd0, dif.busy}, 32'd0);
        chk({nm, "_stall"}, {31'd0, dif.stall_req}, 32'd0);
        chk({nm, "_valid"}, {31'd0, dif.result_valid}, 32'd0);
        chk({nm, "_quotient"}, dif.quotient, q);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int early_lat;
`ifdef DIV_EARLY_OUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        dif.start = 1'b0; dif.signed_op = 1'b0; dif.annul = 1'b0;
        dif.dividend = '0; dif.divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 32'd0);
        chk("reset_remainder", dif.remainder, 32'd0);
        chk("reset_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        rstn = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_div(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
        chk("dbz_clears_in_idle", {31'd0, dif.div_by_zero}, 32'd0);
        run_div(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        // Flush part-way through: no result, previous quotient stays
        issue(1'b0, 32'd50, 32'd5);
        @(posedge clk); #1 dif.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("annul_busy_before", {31'd0, dif.busy}, 32'd1);
        dif.annul = 1'b1;
        @(posedge clk); #1 dif.annul = 1'b0;
        @(negedge clk);
        check_idle_outputs("annul", 32'h8000_0000);
        repeat (40) @(negedge clk);
        // Reset mid-divide, then a fresh divide must still work
        issue(1'b0, 32'd1000, 32'd3);
        @(posedge clk); #1 dif.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid", 32'd0);
        chk("rst_mid_remainder", dif.remainder, 32'd0);
        rstn = 1'b1;
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        run_div(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, early_lat);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
